// File: rtl/tug_round_ctrl_pkg.sv
// Shared types and defaults for the tug-of-war round sequencer.
package tug_round_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    ARMED = 2'd1,
    WIN   = 2'd2
  } state_t;

  localparam int DEF_N_LEDS       = 9;
  localparam int DEF_CLR_CYCLES   = 4;
  localparam int DEF_BLINK_CYCLES = 8;

  function automatic int centre(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/tug_round_ctrl_tick_counter.sv
// Reloadable down-counter; reloads itself on reaching zero or on load.
module tick_counter #(
  parameter int RELOAD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int W = $clog2(RELOAD + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= W'(RELOAD - 1);
    else if (load || zero)
      cnt <= W'(RELOAD - 1);
    else
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tug_round_ctrl.sv
// Round sequencer: moves the rope marker, re-arms the buttons,
// and holds a blinking win display until reset.
module tug_round_ctrl
  import tug_round_ctrl_pkg::*;
#(
  parameter int N_LEDS       = DEF_N_LEDS,
  parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
  parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winrnd,
  input  logic              right,
  input  logic              tie,
  output logic              clr,
  output logic [N_LEDS-1:0] leds,
  output logic              win_left,
  output logic              win_right
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] CTR  = PW'(centre(N_LEDS));
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

  state_t        state;
  logic [PW-1:0] pos;
  logic [PW-1:0] npos;
  logic          phase;
  logic          hold_zero;
  logic          blink_zero;
  logic          at_end;

  tick_counter #(.RELOAD(CLR_CYCLES)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (state != HOLD),
    .zero (hold_zero)
  );

  tick_counter #(.RELOAD(BLINK_CYCLES)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .load (state != WIN),
    .zero (blink_zero)
  );

  always_comb begin
    npos = pos;
    if (tie)
      npos = pos;
    else if (right)
      npos = pos + PW'(1);
    else
      npos = pos - PW'(1);
    at_end = (npos == '0) || (npos == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      pos       <= CTR;
      clr       <= 1'b1;
      leds      <= ONE << CTR;
      win_left  <= 1'b0;
      win_right <= 1'b0;
      phase     <= 1'b1;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_zero) begin
            state <= ARMED;
            clr   <= 1'b0;
          end
        end
        ARMED: begin
          if (winrnd) begin
            pos  <= npos;
            leds <= ONE << npos;
            clr  <= 1'b1;
            if (at_end) begin
              state     <= WIN;
              win_left  <= (npos == '0);
              win_right <= (npos == LAST);
            end else begin
              state <= HOLD;
            end
          end
        end
        WIN: begin
          // Phase register holds the level currently shown.
          if (blink_zero) begin
            phase <= ~phase;
            leds  <= phase ? '0 : ONE << pos;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
